game_irq_scheduler: RTL and testbench
=====================================

Name: game_irq_scheduler

Overview:
Arbitrates three game event sources onto the single KCPSM6 interrupt line: a programmable game tick, button rising edges, and a game_status rising edge. Sources have fixed priority. The block latches the serviced cause for firmware to read, and holds off further interrupts until firmware writes end-of-interrupt (EOI). It sits beside the game port-interface logic on the KCPSM6 port bus. It returns read data through rd_data/rd_hit for the top-level in_port mux.

Parameters:
BASE_DIV, 1000000, clk cycles per base tick (10 ms at 100 MHz); minimum 2
PORT_BASE, 8'h10, first port address; the block decodes PORT_BASE..PORT_BASE+4

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
port_id  in  8  KCPSM6 port address
out_port  in  8  KCPSM6 write data
write_strobe  in  1  KCPSM6 write strobe
read_strobe  in  1  KCPSM6 read strobe
interrupt_ack  in  1  KCPSM6 interrupt acknowledge, 1-cycle pulse
db_btns  in  4  debounced buttons
game_status  in  1  game-over flag, level
interrupt  out  1  interrupt request to KCPSM6, registered
rd_data  out  8  registered read data
rd_hit  out  1  registered; 1 when the previous-cycle port_id was in the decoded range
tick_pulse  out  1  1-cycle pulse on every game tick, independent of tick_en

Behaviour:
- Reset values: interrupt=0, rd_data=0, rd_hit=0, tick_pulse=0; CTRL=3'b001; PERIOD=8'd99; CAUSE=0; pending=0; overrun=0; base and period counters=0; button/status edge history=0; state=IDLE.
- Register map, as offsets from PORT_BASE:
  - +0 CTRL R/W: [0] tick_en, [1] btn_en, [2] stat_en. Reads return [7:3]=0.
  - +1 PERIOD R/W, 8 bits.
  - +2 CAUSE R: [2:0] one-hot serviced source (bit0 tick, bit1 btn, bit2 stat); [7:4] button-edge snapshot; [3]=0.
  - +3 STATUS R: [2:0] pending, [6:4] overrun, [7] 1 when state=SERVICE, [3]=0. A read_strobe with port_id=+3 clears overrun in that cycle. A new overrun event in the same cycle wins.
  - +4 EOI W: data ignored.
- Tick generator: base counter runs 0..BASE_DIV-1. On wrap, the period counter increments. When the period counter equals PERIOD at a wrap, tick_pulse=1 and the period counter returns to 0. Tick period = (PERIOD+1)*BASE_DIV cycles. A write to PERIOD zeroes both counters in that cycle.
- Events:
  - tick: tick_pulse.
  - btn: (db_btns & ~btns_q) != 0. The edge bits are OR-accumulated into btn_acc.
  - stat: game_status & ~stat_q.
  - An event whose enable bit is 0 is discarded.
  - An enabled event whose pending bit is already 1 sets the matching overrun bit.
  - Clearing an enable bit through CTRL also clears that pending bit. For btn, it also clears btn_acc.
  - Simultaneous events all latch.
- FSM:
  - IDLE: if pending != 0, go to REQ next cycle; interrupt=1 from that cycle.
  - REQ: interrupt held at 1 until interrupt_ack.
    - On ack, select the highest-priority pending source (stat > btn > tick) from pending as registered before this cycle.
    - Load CAUSE one-hot; for btn, also load CAUSE[7:4]=btn_acc and clear btn_acc.
    - Clear that pending bit, set interrupt=0, go to SERVICE.
    - An event arriving in the ack cycle sets its pending bit normally.
  - REQ with pending reduced to 0 by CTRL masking: interrupt=0, return to IDLE.
  - SERVICE: interrupt=0. A write to EOI returns to IDLE. If pending != 0, interrupt is re-asserted 2 cycles after the EOI strobe.
  - EOI in IDLE or REQ is ignored.
  - interrupt_ack outside REQ is ignored.
- Reads: rd_data and rd_hit are registered 1 cycle after port_id. Out-of-range port_id gives rd_hit=0 and rd_data=0. Reads have no side effects except the STATUS overrun clear.
- Reset mid-operation: all state returns to reset values at the next clk edge.

Test Plan:
- Tick: BASE_DIV=4, PERIOD=2, CTRL=1 -> tick_pulse every 12 cycles. interrupt rises 2 cycles after tick_pulse. Ack -> CAUSE=8'h01, STATUS[7]=1. EOI -> STATUS=8'h00.
- Priority: raise stat and btn[2] on the same cycle with CTRL=7 -> first ack gives CAUSE=8'h04. After EOI, interrupt re-asserts and the second ack gives CAUSE=8'h42.
- Overrun: two btn edges before ack -> STATUS[5]=1. Read STATUS -> the next read shows STATUS[5]=0. CAUSE[7:4] holds the OR of both edges.
- Masking: btn pending while in REQ, then CTRL=0 -> interrupt=0 next cycle, state returns to IDLE, STATUS=8'h00.
- Register map: write PERIOD=8'h05 -> read +1 gives rd_data=8'h05, rd_hit=1. port_id=8'h20 gives rd_hit=0. A stray EOI in IDLE causes no state change.
- Reset asserted while in REQ -> next cycle interrupt=0, CTRL=8'h01, PERIOD=8'd99.

Source files
------------

// File: rtl/game_irq_scheduler.sv
// game_irq_scheduler: arbitrates game tick, button edges and game_status
// edge onto the KCPSM6 interrupt line. Fixed priority stat > btn > tick;
// the serviced cause is latched for firmware, and further requests are
// held off until firmware writes EOI.
module game_irq_scheduler #(
    parameter int         BASE_DIV  = 1000000,
    parameter logic [7:0] PORT_BASE = 8'h10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       read_strobe,
    input  logic       interrupt_ack,
    input  logic [3:0] db_btns,
    input  logic       game_status,
    output logic       interrupt,
    output logic [7:0] rd_data,
    output logic       rd_hit,
    output logic       tick_pulse
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    localparam int            BW        = $clog2(BASE_DIV);
    localparam logic [BW-1:0] BASE_LAST = BW'(BASE_DIV - 1);

    // Registers
    logic [BW-1:0] r_base_cnt;
    logic [7:0]    r_period_cnt;
    logic          r_tick_pulse;
    logic [2:0]    r_ctrl;
    logic [7:0]    r_period;
    logic [7:0]    r_cause;
    logic [2:0]    r_pending;
    logic [2:0]    r_overrun;
    logic [3:0]    r_btn_acc;
    logic [3:0]    r_btns_q;
    logic          r_stat_q;
    logic          r_irq;
    logic [7:0]    r_rd_data;
    logic          r_rd_hit;
    state_t        r_state;

    // Combinational
    logic [7:0] w_off;
    logic       w_in_range;
    logic       w_wr_ctrl;
    logic       w_wr_period;
    logic       w_wr_eoi;
    logic       w_rd_status;
    logic [2:0] w_en;
    logic [3:0] w_btn_edge;
    logic [2:0] w_evt;
    logic       w_ack;
    logic [2:0] w_grant;
    logic [2:0] w_ack_clr;
    logic [2:0] w_pending_n;
    logic [2:0] w_ovr_evt;
    state_t     w_state_n;
    logic       w_irq_n;

    // Port decode: modular offset handles a range that wraps past 8'hFF
    assign w_off       = port_id - PORT_BASE;
    assign w_in_range  = (w_off < 8'd5);
    assign w_wr_ctrl   = write_strobe && (w_off == 8'd0);
    assign w_wr_period = write_strobe && (w_off == 8'd1);
    assign w_wr_eoi    = write_strobe && (w_off == 8'd4);
    assign w_rd_status = read_strobe  && (w_off == 8'd3);

    // Enables as they stand after this cycle, so a masking CTRL write
    // discards same-cycle events and drops pending bits at once
    assign w_en       = w_wr_ctrl ? out_port[2:0] : r_ctrl;
    assign w_btn_edge = db_btns & ~r_btns_q;
    assign w_evt      = {game_status & ~r_stat_q, |w_btn_edge, r_tick_pulse} & w_en;

    assign w_ack = (r_state == S_REQ) && interrupt_ack;

    // Highest-priority pending source, taken from last cycle's pending
    always_comb begin
        w_grant = 3'b000;
        if (r_pending[2])      w_grant = 3'b100;
        else if (r_pending[1]) w_grant = 3'b010;
        else if (r_pending[0]) w_grant = 3'b001;
    end

    assign w_ack_clr   = w_ack ? w_grant : 3'b000;
    assign w_pending_n = ((r_pending & ~w_ack_clr) | w_evt) & w_en;
    // A bit that is being serviced this cycle is free to take a new event
    assign w_ovr_evt   = w_evt & r_pending & ~w_ack_clr;

    // Base/period counters producing the game tick; PERIOD write restarts them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base_cnt   <= '0;
            r_period_cnt <= 8'd0;
            r_tick_pulse <= 1'b0;
        end else begin
            r_tick_pulse <= 1'b0;
            if (w_wr_period) begin
                r_base_cnt   <= '0;
                r_period_cnt <= 8'd0;
            end else if (r_base_cnt == BASE_LAST) begin
                r_base_cnt <= '0;
                if (r_period_cnt == r_period) begin
                    r_period_cnt <= 8'd0;
                    r_tick_pulse <= 1'b1;
                end else begin
                    r_period_cnt <= r_period_cnt + 8'd1;
                end
            end else begin
                r_base_cnt <= r_base_cnt + 1'b1;
            end
        end
    end

    // Firmware-writable control and period registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl   <= 3'b001;
            r_period <= 8'd99;
        end else begin
            if (w_wr_ctrl)   r_ctrl   <= out_port[2:0];
            if (w_wr_period) r_period <= out_port;
        end
    end

    // Edge-detect history for buttons and game_status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btns_q <= 4'd0;
            r_stat_q <= 1'b0;
        end else begin
            r_btns_q <= db_btns;
            r_stat_q <= game_status;
        end
    end

    // Pending and overrun bookkeeping; a fresh overrun beats the read clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 3'd0;
            r_overrun <= 3'd0;
        end else begin
            r_pending <= w_pending_n;
            r_overrun <= (w_rd_status ? 3'd0 : r_overrun) | w_ovr_evt;
        end
    end

    // Button-edge accumulator, handed to CAUSE when the btn source is serviced
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_acc <= 4'd0;
        end else if (!w_en[1]) begin
            r_btn_acc <= 4'd0;
        end else begin
            r_btn_acc <= (w_ack_clr[1] ? 4'd0 : r_btn_acc) | w_btn_edge;
        end
    end

    // Latch the serviced cause on acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cause <= 8'd0;
        end else if (w_ack && (w_grant != 3'b000)) begin
            r_cause <= {(w_grant[1] ? r_btn_acc : 4'd0), 1'b0, w_grant};
        end
    end

    // FSM state and registered interrupt line
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_irq   <= w_irq_n;
        end
    end

    // FSM next state; interrupt is asserted exactly while the next state is REQ
    always_comb begin
        w_state_n = r_state;
        w_irq_n   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_pending & w_en) != 3'd0) begin
                    w_state_n = S_REQ;
                    w_irq_n   = 1'b1;
                end
            end
            S_REQ: begin
                if (w_ack) begin
                    w_state_n = S_SERVICE;
                end else if (w_pending_n == 3'd0) begin
                    w_state_n = S_IDLE;
                end else begin
                    w_irq_n = 1'b1;
                end
            end
            S_SERVICE: begin
                if (w_wr_eoi) w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // Registered read-back for the top-level in_port mux
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= 8'd0;
            r_rd_hit  <= 1'b0;
        end else begin
            r_rd_hit <= w_in_range;
            case (w_off)
                8'd0:    r_rd_data <= {5'd0, r_ctrl};
                8'd1:    r_rd_data <= r_period;
                8'd2:    r_rd_data <= r_cause;
                8'd3:    r_rd_data <= {(r_state == S_SERVICE), r_overrun, 1'b0, r_pending};
                default: r_rd_data <= 8'd0;
            endcase
        end
    end

    assign interrupt  = r_irq;
    assign rd_data    = r_rd_data;
    assign rd_hit     = r_rd_hit;
    assign tick_pulse = r_tick_pulse;

endmodule

// File: tb/tb_game_irq_scheduler.sv
// Bench for game_irq_scheduler: scenario tasks with inline comparisons,
// randomized event mixes checked against an expected-cause queue.
module tb_game_irq_scheduler;

    localparam logic [7:0] PB = 8'h10;
    localparam int         BD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] port_id = 8'd0;
    logic [7:0] out_port = 8'd0;
    logic       write_strobe = 1'b0;
    logic       read_strobe = 1'b0;
    logic       interrupt_ack = 1'b0;
    logic [3:0] db_btns = 4'd0;
    logic       game_status = 1'b0;
    logic       interrupt;
    logic [7:0] rd_data;
    logic       rd_hit;
    logic       tick_pulse;

    int checks = 0;
    int errors = 0;

    game_irq_scheduler #(.BASE_DIV(BD), .PORT_BASE(PB)) dut (
        .clk(clk), .rst(rst), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .read_strobe(read_strobe),
        .interrupt_ack(interrupt_ack), .db_btns(db_btns), .game_status(game_status),
        .interrupt(interrupt), .rd_data(rd_data), .rd_hit(rd_hit), .tick_pulse(tick_pulse)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] off, input logic [7:0] d);
        port_id = PB + off; out_port = d; write_strobe = 1'b1;
        step();
        write_strobe = 1'b0; port_id = 8'd0; out_port = 8'd0;
    endtask

    task automatic rd(input logic [7:0] addr, output logic [7:0] d, output logic h);
        port_id = addr; read_strobe = 1'b1;
        step();
        d = rd_data; h = rd_hit;
        read_strobe = 1'b0; port_id = 8'd0;
    endtask

    task automatic ack();
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
    endtask

    task automatic wait_irq(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= lim; i++) begin
            if (interrupt === 1'b1) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic test_reset();
        logic [7:0] d; logic h;
        rst = 1'b1;
        step(); step();
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", interrupt); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got %h exp 00", rd_data); end
        checks++; if (rd_hit !== 1'b0) begin errors++; $display("FAIL rst_rd_hit got %b exp 0", rd_hit); end
        checks++; if (tick_pulse !== 1'b0) begin errors++; $display("FAIL rst_tick got %b exp 0", tick_pulse); end
        rst = 1'b0;
        rd(PB + 8'd0, d, h);
        checks++; if (d !== 8'h01 || h !== 1'b1) begin errors++; $display("FAIL rst_ctrl got %h/%b exp 01/1", d, h); end
        rd(PB + 8'd1, d, h);
        checks++; if (d !== 8'd99) begin errors++; $display("FAIL rst_period got %h exp %h", d, 8'd99); end
        rd(PB + 8'd2, d, h);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_cause got %h exp 00", d); end
        rd(PB + 8'd3, d, h);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_status got %h exp 00", d); end
    endtask

    // Tick every (p+1)*BD cycles after the PERIOD write; irq two cycles later
    task automatic test_tick(input int p);
        logic [7:0] d; logic h;
        int t;
        t = (p + 1) * BD;
        wr(8'd0, 8'h01);
        wr(8'd1, 8'(p));
        for (int n = 0; n <= t + 2; n++) begin
            checks++;
            if (tick_pulse !== (n == t)) begin errors++; $display("FAIL tick_pulse n=%0d got %b exp %b", n, tick_pulse, (n == t)); end
            checks++;
            if (interrupt !== (n >= t + 2)) begin errors++; $display("FAIL tick_irq n=%0d got %b exp %b", n, interrupt, (n >= t + 2)); end
            if (n < t + 2) step();
        end
        ack();
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL tick_irq_after_ack got %b exp 0", interrupt); end
        rd(PB + 8'd2, d, h);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL tick_cause got %h exp 01", d); end
        rd(PB + 8'd3, d, h);
        checks++; if (d !== 8'h80) begin errors++; $display("FAIL tick_status_svc got %h exp 80", d); end
        wr(8'd4, 8'h00);
        rd(PB + 8'd3, d, h);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL tick_status_eoi got %h exp 00", d); end
        wr(8'd0, 8'h00);
    endtask

    task automatic test_priority();
        logic [7:0] d; logic h; bit ok;
        wr(8'd1, 8'd255);
        wr(8'd0, 8'h07);
        db_btns = 4'b0100; game_status = 1'b1;
        step();
        wait_irq(6, ok);
        checks++; if (!ok) begin errors++; $display("FAIL prio_irq1 got 0 exp 1"); end
        ack();
        rd(PB + 8'd2, d, h);
        checks++; if (d !== 8'h04) begin errors++; $display("FAIL prio_cause1 got %h exp 04", d); end
        ack();  // stray ack while in SERVICE
        rd(PB + 8'd2, d, h);
        checks++; if (d !== 8'h04) begin errors++; $display("FAIL prio_stray_ack got %h exp 04", d); end
        rd(PB + 8'd3, d, h);
        checks++; if (d !== 8'h82) begin errors++; $display("FAIL prio_status got %h exp 82", d); end
        wr(8'd4, 8'h00);
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL prio_eoi_plus1 got %b exp 0", interrupt); end
        step();
        checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL prio_eoi_plus2 got %b exp 1", interrupt); end
        ack();
        rd(PB + 8'd2, d, h);
        checks++; if (d !== 8'h42) begin errors++; $display("FAIL prio_cause2 got %h exp 42", d); end
        wr(8'd4, 8'h00);
        rd(PB + 8'd3, d, h);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL prio_status_end got %h exp 00", d); end
        db_btns = 4'd0; game_status = 1'b0;
        step();
        wr(8'd0, 8'h00);
    endtask

    // Random stat/btn mixes; expected service order comes from priority alone
    task automatic test_random(input int iters);
        logic [7:0] d; logic h; bit ok;
        logic [7:0] exp_q[$];
        logic [7:0] e;
        logic [3:0] m;
        bit s, dly;
        wr(8'd1, 8'd255);
        wr(8'd0, 8'h06);
        for (int it = 0; it < iters; it++) begin
            s   = 1'($urandom_range(0, 1));
            m   = 4'($urandom_range(0, 15));
            dly = 1'($urandom_range(0, 1));
            if (!s && m == 4'd0) s = 1'b1;
            exp_q.delete();
            if (s) exp_q.push_back(8'h04);
            if (m != 4'd0) exp_q.push_back({m, 4'h2});
            repeat ($urandom_range(0, 3)) step();
            if (s) game_status = 1'b1;
            if (dly) step();
            db_btns = m;
            step();
            db_btns = 4'd0; game_status = 1'b0;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                wait_irq(8, ok);
                checks++; if (!ok) begin errors++; $display("FAIL rand_irq it=%0d got 0 exp 1", it); end
                ack();
                rd(PB + 8'd2, d, h);
                checks++; if (d !== e) begin errors++; $display("FAIL rand_cause it=%0d got %h exp %h", it, d, e); end
                wr(8'd4, 8'h00);
            end
            step(); step(); step();
            checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rand_idle_irq it=%0d got %b exp 0", it, interrupt); end
            rd(PB + 8'd3, d, h);
            checks++; if (d !== 8'h00) begin errors++; $display("FAIL rand_status it=%0d got %h exp 00", it, d); end
        end
        wr(8'd0, 8'h00);
    endtask

    task automatic test_overrun();
        logic [7:0] d; logic h;
        logic [3:0] a, b;
        a = 4'($urandom_range(1, 15));
        b = 4'($urandom_range(1, 15));
        wr(8'd0, 8'h02);
        db_btns = a; step();
        db_btns = 4'd0; step();
        db_btns = b; step();
        db_btns = 4'd0; step();
        rd(PB + 8'd3, d, h);
        checks++; if (d !== 8'h22) begin errors++; $display("FAIL ovr_status1 got %h exp 22", d); end
        rd(PB + 8'd3, d, h);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL ovr_status2 got %h exp 02", d); end
        checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL ovr_irq got %b exp 1", interrupt); end
        ack();
        rd(PB + 8'd2, d, h);
        checks++; if (d !== {a | b, 4'h2}) begin errors++; $display("FAIL ovr_cause got %h exp %h", d, {a | b, 4'h2}); end
        wr(8'd4, 8'h00);
        rd(PB + 8'd3, d, h);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL ovr_status_end got %h exp 00", d); end
        wr(8'd0, 8'h00);
    endtask

    task automatic test_masking();
        logic [7:0] d; logic h; bit ok;
        logic [3:0] c;
        c = 4'($urandom_range(1, 7));
        wr(8'd0, 8'h02);
        db_btns = 4'b1000; step();
        db_btns = 4'd0;
        wait_irq(6, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mask_irq got 0 exp 1"); end
        rd(PB + 8'd3, d, h);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL mask_status_req got %h exp 02", d); end
        wr(8'd0, 8'h00);
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL mask_irq_drop got %b exp 0", interrupt); end
        rd(PB + 8'd3, d, h);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL mask_status got %h exp 00", d); end
        db_btns = 4'hF; step();
        db_btns = 4'd0; step(); step(); step();
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL mask_discard got %b exp 0", interrupt); end
        wr(8'd0, 8'h02);
        db_btns = c; step();
        db_btns = 4'd0;
        wait_irq(6, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mask_irq2 got 0 exp 1"); end
        ack();
        rd(PB + 8'd2, d, h);
        checks++; if (d !== {c, 4'h2}) begin errors++; $display("FAIL mask_acc_clear got %h exp %h", d, {c, 4'h2}); end
        wr(8'd4, 8'h00);
        wr(8'd0, 8'h00);
    endtask

    task automatic test_regmap();
        logic [7:0] d; logic h;
        wr(8'd1, 8'h05);
        rd(PB + 8'd1, d, h);
        checks++; if (d !== 8'h05 || h !== 1'b1) begin errors++; $display("FAIL map_period got %h/%b exp 05/1", d, h); end
        rd(8'h20, d, h);
        checks++; if (d !== 8'h00 || h !== 1'b0) begin errors++; $display("FAIL map_out_hi got %h/%b exp 00/0", d, h); end
        rd(PB - 8'd1, d, h);
        checks++; if (d !== 8'h00 || h !== 1'b0) begin errors++; $display("FAIL map_out_lo got %h/%b exp 00/0", d, h); end
        rd(PB + 8'd4, d, h);
        checks++; if (d !== 8'h00 || h !== 1'b1) begin errors++; $display("FAIL map_eoi_rd got %h/%b exp 00/1", d, h); end
        wr(8'd0, 8'hFF);
        rd(PB + 8'd0, d, h);
        checks++; if (d !== 8'h07) begin errors++; $display("FAIL map_ctrl_bits got %h exp 07", d); end
        wr(8'd0, 8'h00);
        wr(8'd4, 8'hA5);
        rd(PB + 8'd3, d, h);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL map_stray_eoi got %h exp 00", d); end
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL map_stray_irq got %b exp 0", interrupt); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d; logic h; bit ok;
        wr(8'd1, 8'd255);
        wr(8'd0, 8'h02);
        db_btns = 4'b0001; step();
        db_btns = 4'd0;
        wait_irq(6, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_irq got 0 exp 1"); end
        rst = 1'b1;
        step();
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rmid_irq_clear got %b exp 0", interrupt); end
        rst = 1'b0;
        rd(PB + 8'd0, d, h);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL rmid_ctrl got %h exp 01", d); end
        rd(PB + 8'd1, d, h);
        checks++; if (d !== 8'd99) begin errors++; $display("FAIL rmid_period got %h exp %h", d, 8'd99); end
        rd(PB + 8'd3, d, h);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rmid_status got %h exp 00", d); end
    endtask

    initial begin
        test_reset();
        test_tick(2);
        test_tick($urandom_range(2, 5));
        test_priority();
        test_random(10);
        test_overrun();
        test_masking();
        test_regmap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
